// File: rtl/multi_edge_detector_if.sv
// Bundles the per-channel level, mode and clear inputs with the edge and status outputs of multi_edge_detector.
interface multi_edge_detector_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]   level;
    logic [2*CHANNELS-1:0] mode;
    logic [CHANNELS-1:0]   clr;
    logic [CHANNELS-1:0]   pulse;
    logic [CHANNELS-1:0]   rise;
    logic [CHANNELS-1:0]   fall;
    logic                  any_edge;
    logic [CHANNELS-1:0]   status;

    modport master (
        output level, mode, clr,
        input  pulse, rise, fall, any_edge, status
    );

    modport slave (
        input  level, mode, clr,
        output pulse, rise, fall, any_edge, status
    );
endinterface

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: synchroniser, glitch filter and Moore edge FSM per channel, with mode gating.
// Define EDGE_STICKY_EN to build the sticky status flags (cleared by clr); otherwise status is tied to 0.
module multi_edge_detector #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 2
) (
    input logic                  clk,
    input logic                  reset,
    multi_edge_detector_if.slave bus
);
    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    typedef enum logic [1:0] {
        LOW  = 2'b00,
        RISE = 2'b01,
        HIGH = 2'b10,
        FALL = 2'b11
    } edge_state_e;

    logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CHANNELS-1:0]                  synced;
    logic [CHANNELS-1:0]                  filt_q, filt_d;
    logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    edge_state_e [CHANNELS-1:0]           state_q, state_d;
    logic [CHANNELS-1:0]                  rise, fall, pulse;

    // Each chain shifts the raw level in at bit 0; the top bit is the synchronised value.
    always_comb begin
        sync_d = sync_q;
        synced = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sync_d[i] = SYNC_STAGES'({sync_q[i], bus.level[i]});
            synced[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (synced[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                filt_d[i] = synced[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // RISE and FALL last one cycle each; a back-to-back change jumps straight to the opposite pulse state.
    always_comb begin
        state_d = state_q;
        for (int i = 0; i < CHANNELS; i++) begin
            unique case (state_q[i])
                LOW:     state_d[i] = filt_q[i] ? RISE : LOW;
                RISE:    state_d[i] = filt_q[i] ? HIGH : FALL;
                HIGH:    state_d[i] = filt_q[i] ? HIGH : FALL;
                FALL:    state_d[i] = filt_q[i] ? RISE : LOW;
                default: state_d[i] = LOW;
            endcase
        end
    end

    always_comb begin
        rise  = '0;
        fall  = '0;
        pulse = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rise[i]  = (state_q[i] == RISE);
            fall[i]  = (state_q[i] == FALL);
            pulse[i] = (bus.mode[2*i] & rise[i]) | (bus.mode[2*i+1] & fall[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            filt_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= LOW;
            end
        end else begin
            sync_q  <= sync_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign bus.rise     = rise;
    assign bus.fall     = fall;
    assign bus.pulse    = pulse;
    assign bus.any_edge = |pulse;

`ifdef EDGE_STICKY_EN
    logic [CHANNELS-1:0] status_q, status_d;

    // A pulse takes priority over a clear arriving in the same cycle.
    always_comb begin
        status_d = pulse | (status_q & ~bus.clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign bus.status = status_q;
`else
    logic [CHANNELS-1:0] unused_clr;

    assign unused_clr = bus.clr;
    assign bus.status = '0;
`endif
endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, meaning number of independent level inputs (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flops per channel (1..4).
REQ-003 SHALL have parameter FILTER_LEN, default 2, meaning consecutive stable cycles required before a level change is accepted (1..15).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all flops on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous, active-low reset.
REQ-006 SHALL have port level, input, CHANNELS, meaning raw asynchronous level per channel.
REQ-007 SHALL have port mode, input, 2*CHANNELS, meaning per-channel select in bits [2i+1:2i]: 00 none, 01 rising, 10 falling, 11 both.
REQ-008 SHALL have port clr, input, CHANNELS, meaning per-channel sticky-flag clear, active-high.
REQ-009 SHALL have port pulse, output, CHANNELS, meaning one-cycle edge pulse per channel after mode gating.
REQ-010 SHALL have port rise, output, CHANNELS, meaning ungated rising-edge pulse per channel.
REQ-011 SHALL have port fall, output, CHANNELS, meaning ungated falling-edge pulse per channel.
REQ-012 SHALL have port any_edge, output, 1, meaning OR-reduction of pulse.
REQ-013 SHALL have port status, output, CHANNELS, meaning sticky edge flags.

Function
REQ-014 Each channel SHALL pass level through a SYNC_STAGES-deep flop chain; the last stage is the synced value s.
REQ-015 Each channel SHALL hold a filtered value f and a counter of width clog2(FILTER_LEN+1); counter increments while s != f, clears when s == f; when the counter reaches FILTER_LEN-1 with s != f, f loads s and the counter clears.
REQ-016 Each channel SHALL run a Moore FSM on f with states LOW=00, RISE=01, HIGH=10, FALL=11.
REQ-017 Transitions: LOW: f=1 -> RISE, else LOW; RISE: f=1 -> HIGH, f=0 -> FALL; HIGH: f=0 -> FALL, else HIGH; FALL: f=0 -> LOW, f=1 -> RISE.
REQ-018 rise[i] SHALL be 1 only in RISE; fall[i] SHALL be 1 only in FALL; both are decoded from state only (Moore, no combinational path from level or mode).
REQ-019 pulse[i] SHALL equal (mode[2i] & rise[i]) | (mode[2i+1] & fall[i]); mode MAY change any cycle and takes effect the same cycle.
REQ-020 A level change held stable SHALL produce its rise/fall pulse exactly SYNC_STAGES+FILTER_LEN+1 clock edges after the first edge sampling the new value (defaults: 5).
REQ-021 A level glitch shorter than FILTER_LEN synced cycles SHALL produce no pulse and leave f unchanged.
REQ-022 Every accepted change of f SHALL produce exactly one one-cycle pulse of the matching type; back-to-back accepted changes (FILTER_LEN=1) SHALL produce alternating rise/fall pulses with none lost.
REQ-023 Channels SHALL be fully independent; simultaneous edges on several channels SHALL all be reported in the same cycle.

Reset
REQ-024 While reset=0, all sync flops, f, counters SHALL be 0, all FSMs LOW, and pulse, rise, fall, any_edge, status SHALL be 0.
REQ-025 Reset asserted mid-operation SHALL take effect immediately (asynchronous) and discard any partly counted edge.
REQ-026 After release, a level held at 1 SHALL be reported as a rising edge with REQ-020 latency.

Configuration
REQ-027 With macro EDGE_STICKY_EN defined, status[i] SHALL set on the cycle after pulse[i]=1, clear on the cycle after clr[i]=1, set winning when both occur together.
REQ-028 Without EDGE_STICKY_EN, status SHALL be constant 0, clr SHALL be ignored, and no sticky flops SHALL be built; the port list is identical.

Verification
REQ-029 Defaults, mode=01 on ch0, level[0] 0->1 held -> rise[0], pulse[0], any_edge high for exactly one cycle, 5 edges after sampling.
REQ-030 Defaults, level[1] 1-cycle high glitch -> no pulse, rise or fall on any channel.
REQ-031 mode=10 on ch2, level[2] 0->1->0 each held 10 cycles -> rise[2] pulses but pulse[2] only on the fall; mode=00 -> pulse[2] never asserts.
REQ-032 FILTER_LEN=1, SYNC_STAGES=1, level[3] toggles every cycle for 8 cycles -> 8 alternating rise/fall pulses, none dropped.
REQ-033 EDGE_STICKY_EN, edge on ch0 with clr[0]=1 in the pulse cycle -> status[0]=1; clr[0] next cycle -> status[0]=0.
REQ-034 reset=0 asserted during filter count on ch1 -> all outputs 0 immediately; after release with level[1]=1 -> single rise after 5 edges.
